// File: rtl/matmul_apb_master_pkg.sv
// Shared types and defaults for the matmul APB master.
// Holds the FSM state enum, the default-width command/response payloads
// and the default watchdog length.
package matmul_apb_master_pkg;

  localparam int unsigned APB_MST_ADDR_WIDTH     = 16;
  localparam int unsigned APB_MST_BUS_WIDTH      = 32;
  localparam int unsigned APB_MST_STRB_WIDTH     = APB_MST_BUS_WIDTH / 8;
  localparam int unsigned APB_MST_TIMEOUT_CYCLES = 256;
  localparam int unsigned APB_MST_STATE_W        = 3;

  typedef enum logic [APB_MST_STATE_W-1:0] {
    APB_IDLE      = 3'd0,
    APB_WAIT_IDLE = 3'd1,
    APB_SETUP     = 3'd2,
    APB_ACCESS    = 3'd3,
    APB_RESP      = 3'd4
  } apb_mst_state_e;

  // Command as presented by the loader/sequencer (default widths).
  typedef struct packed {
    logic                          write;
    logic [APB_MST_ADDR_WIDTH-1:0] addr;
    logic [APB_MST_BUS_WIDTH-1:0]  wdata;
    logic [APB_MST_STRB_WIDTH-1:0] strb;
    logic                          wait_idle;
  } apb_cmd_t;

  // Response returned to the loader/sequencer (default widths).
  typedef struct packed {
    logic [APB_MST_BUS_WIDTH-1:0] rdata;
    logic                         err;
    logic                         timeout;
  } apb_rsp_t;

endpackage

// File: rtl/matmul_apb_master.sv
// APB master feeding matmul's slave port from a valid/ready command channel.
// Optional wait-for-idle gating on busy_i, pready watchdog, held response.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cmd_*                         command request channel (valid/ready)
//   rsp_*                         response channel (valid/ready)
//   busy_i                        matmul busy, used only for wait_idle commands
//   paddr_o..pstrb_o, pready_i..  APB master interface
module matmul_apb_master
  import matmul_apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_MST_ADDR_WIDTH,
  parameter int unsigned BUS_WIDTH      = APB_MST_BUS_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = APB_MST_TIMEOUT_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]   cmd_wdata_i,
  input  logic [BUS_WIDTH/8-1:0] cmd_strb_i,
  input  logic                   cmd_wait_idle_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   rsp_timeout_o,
  input  logic                   busy_i,
  output logic [ADDR_WIDTH-1:0]  paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [BUS_WIDTH-1:0]   pwdata_o,
  output logic [BUS_WIDTH/8-1:0] pstrb_o,
  input  logic                   pready_i,
  input  logic                   pslverr_i,
  input  logic [BUS_WIDTH-1:0]   prdata_i
);

  localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [APB_MST_STATE_W-1:0] IDLE      = APB_MST_STATE_W'(APB_IDLE);
  localparam logic [APB_MST_STATE_W-1:0] WAIT_IDLE = APB_MST_STATE_W'(APB_WAIT_IDLE);
  localparam logic [APB_MST_STATE_W-1:0] SETUP     = APB_MST_STATE_W'(APB_SETUP);
  localparam logic [APB_MST_STATE_W-1:0] ACCESS    = APB_MST_STATE_W'(APB_ACCESS);
  localparam logic [APB_MST_STATE_W-1:0] RESP      = APB_MST_STATE_W'(APB_RESP);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [STRB_WIDTH-1:0] strb;
    logic                  wait_idle;
  } cmd_t;

  logic [APB_MST_STATE_W-1:0] r_state;
  logic [APB_MST_STATE_W-1:0] w_state_nxt;
  cmd_t                       r_cmd;
  cmd_t                       w_cmd_in;
  logic [CNT_WIDTH-1:0]       r_tmo_cnt;
  logic                       w_cmd_hs;
  logic                       w_tmo_hit;
  logic                       w_load_apb;
  logic                       w_src_write;
  logic [ADDR_WIDTH-1:0]      w_src_addr;
  logic [BUS_WIDTH-1:0]       w_src_wdata;
  logic [STRB_WIDTH-1:0]      w_src_strb;

  logic [ADDR_WIDTH-1:0]      r_paddr;
  logic                       r_pwrite;
  logic [BUS_WIDTH-1:0]       r_pwdata;
  logic [STRB_WIDTH-1:0]      r_pstrb;
  logic [BUS_WIDTH-1:0]       r_rsp_rdata;
  logic                       r_rsp_err;
  logic                       r_rsp_timeout;

  assign w_cmd_in = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i,
                      strb: cmd_strb_i, wait_idle: cmd_wait_idle_i};

  assign w_cmd_hs  = cmd_valid_i & cmd_ready_o;
  assign w_tmo_hit = (r_state == ACCESS) & ~pready_i & (r_tmo_cnt == CNT_LAST);

  // SETUP entered straight from IDLE uses the live command, otherwise the latched one.
  assign w_load_apb  = (w_state_nxt == SETUP) & (r_state != SETUP);
  assign w_src_write = (r_state == IDLE) ? cmd_write_i : r_cmd.write;
  assign w_src_addr  = (r_state == IDLE) ? cmd_addr_i  : r_cmd.addr;
  assign w_src_wdata = (r_state == IDLE) ? cmd_wdata_i : r_cmd.wdata;
  assign w_src_strb  = (r_state == IDLE) ? cmd_strb_i  : r_cmd.strb;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and state-decoded outputs; ready is masked while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready_o = ~rst_i;
        if (w_cmd_hs) w_state_nxt = (cmd_wait_idle_i & busy_i) ? WAIT_IDLE : SETUP;
      end
      WAIT_IDLE: begin
        if (!(r_cmd.wait_idle & busy_i)) w_state_nxt = SETUP;
      end
      SETUP: begin
        psel_o      = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i | w_tmo_hit) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command latch, APB drive registers, watchdog and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd         <= '0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_tmo_cnt     <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_cmd_hs) r_cmd <= w_cmd_in;
      if (w_load_apb) begin
        r_paddr  <= w_src_addr;
        r_pwrite <= w_src_write;
        r_pwdata <= w_src_wdata;
        r_pstrb  <= w_src_write ? w_src_strb : '0;
      end
      if ((r_state == ACCESS) & ~pready_i & ~w_tmo_hit) r_tmo_cnt <= r_tmo_cnt + CNT_WIDTH'(1);
      else                                              r_tmo_cnt <= '0;
      if (r_state == ACCESS) begin
        if (pready_i) begin
          r_rsp_rdata   <= r_pwrite ? '0 : prdata_i;
          r_rsp_err     <= pslverr_i;
          r_rsp_timeout <= 1'b0;
        end else if (w_tmo_hit) begin
          r_rsp_rdata   <= '0;
          r_rsp_err     <= 1'b1;
          r_rsp_timeout <= 1'b1;
        end
      end
    end
  end

  assign paddr_o       = r_paddr;
  assign pwrite_o      = r_pwrite;
  assign pwdata_o      = r_pwdata;
  assign pstrb_o       = r_pstrb;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: doc/matmul_apb_master.md
Name: matmul_apb_master

Overview:
- Upstream stage of the matmul block: turns simple command requests from a loader/sequencer into AMBA APB transfers on matmul's slave port.
- Adds optional wait-for-idle gating on matmul's busy output, a pready timeout watchdog and a buffered response channel.
- Used in the verification environment and the integration top, so operand loads, start writes and result reads all go through one protocol-correct master.

Parameters:
- ADDR_WIDTH, 16, APB address width (must match matmul ADDR_WIDTH)
- BUS_WIDTH, 32, APB data width (must match matmul BUS_WIDTH)
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles waiting for pready before abort; must be >= 2

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command request valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  BUS_WIDTH  write data
- cmd_strb_i  in  BUS_WIDTH/8  byte strobes
- cmd_wait_idle_i  in  1  hold transfer until busy_i low
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  BUS_WIDTH  read data (0 for writes)
- rsp_err_o  out  1  pslverr captured or timeout
- rsp_timeout_o  out  1  transfer aborted by watchdog
- busy_i  in  1  matmul busy
- paddr_o  out  ADDR_WIDTH  APB paddr
- psel_o  out  1  APB psel
- penable_o  out  1  APB penable
- pwrite_o  out  1  APB pwrite
- pwdata_o  out  BUS_WIDTH  APB pwdata
- pstrb_o  out  BUS_WIDTH/8  APB pstrb
- pready_i  in  1  APB pready
- pslverr_i  in  1  APB pslverr
- prdata_i  in  BUS_WIDTH  APB prdata

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i. All state is updated on the posedge.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- FSM states: IDLE, WAIT_IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, latch write, addr, wdata, strb and wait_idle.
  - Next state is WAIT_IDLE if cmd_wait_idle_i & busy_i, otherwise SETUP.
- WAIT_IDLE:
  - cmd_ready_o = 0, psel_o = 0.
  - Go to SETUP in the first cycle busy_i is sampled 0.
  - No timeout applies in this state.
- SETUP (exactly 1 cycle):
  - psel_o = 1, penable_o = 0.
  - paddr_o, pwrite_o, pwdata_o, pstrb_o are driven from the latched values.
  - pstrb_o is forced to 0 for reads.
- ACCESS:
  - psel_o = 1, penable_o = 1; all APB outputs stay stable.
  - The timeout counter increments each cycle with pready_i = 0.
  - On pready_i = 1: capture prdata_i (reads only, else 0) and pslverr_i, then go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with pready_i still 0: drop psel_o/penable_o next cycle, set err = 1, timeout = 1, rdata = 0, go to RESP.
- RESP:
  - rsp_valid_o = 1 with payload held stable until rsp_ready_i.
  - Then go to IDLE and clear rsp_valid_o. The timeout counter clears on leaving ACCESS.
- psel_o and penable_o are combinational decodes of the registered state, so they are glitch-free.
- paddr/pwdata/pstrb/pwrite are registered and hold their last values in IDLE. Only psel_o = 0 is guaranteed there.
- Latency: handshake at cycle N → SETUP at N+1 → ACCESS at N+2. With zero-wait pready, rsp_valid_o = 1 at N+3. Each pready wait cycle adds 1.
- Throughput: with rsp_ready_i tied high, at most one transfer per 4 cycles. No command is accepted while a response is pending.
- Simultaneous cmd_valid_i and busy_i with wait_idle = 0: the transfer proceeds and busy_i is ignored.
- Reset mid-transfer: on the next edge psel/penable go to 0, state goes to IDLE, and any pending response is discarded (rsp_valid_o = 0).
- pslverr_i is sampled only in the ACCESS cycle where pready_i = 1.

Decomposition:
- Add to verif_package / shared package:
  - apb_mst_state_e enum (IDLE, WAIT_IDLE, SETUP, ACCESS, RESP)
  - apb_cmd_t struct (write, addr, wdata, strb, wait_idle)
  - apb_rsp_t struct (rdata, err, timeout)
  - the TIMEOUT_CYCLES default constant
- No sub-module needed. The watchdog is a single counter of width $clog2(TIMEOUT_CYCLES) inside the FSM module.

Test Plan:
- Write addr 0x0010, data 0xDEADBEEF, strb 0xF, pready tied 1 → psel rises N+1, penable N+2, rsp_valid N+3 with err 0 and rdata 0.
- Read addr 0x0020, slave returns 0x12345678 after 3 wait cycles → penable held 4 cycles with stable paddr, rsp_rdata 0x12345678, pstrb 0 throughout.
- Write with wait_idle = 1 while busy_i high for 10 cycles → psel stays 0 for 10 cycles, SETUP starts the cycle after busy_i falls.
- pready never asserted, TIMEOUT_CYCLES = 8 → ACCESS lasts 8 cycles, then psel drops and the response shows err = 1, timeout = 1.
- Slave returns pslverr = 1 with pready → rsp_err 1, rsp_timeout 0. Hold rsp_ready 0 for 5 cycles → payload stable and cmd_ready 0 throughout.
- Assert rst_i during ACCESS → next cycle psel/penable/rsp_valid are 0 and cmd_ready is 1. A new command then completes normally.
